sram_word_controller: RTL

- Sits between the memory stage and the external 16-bit SRAM pins.
- Turns each 32-bit load or store into two sequential 16-bit SRAM accesses: low half first, then high half.
- Drives `ready` low while an access is in progress; the top level uses `~ready` as the pipeline-wide RAM freeze.
- Fixed-latency, FSM-driven, with no external handshake from the SRAM.

---
 rtl/sram_word_controller.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sram_word_controller.sv
`timescale 1ns/1ps
// Splits each 32-bit load/store into two timed 16-bit SRAM accesses (low half, then high half).
// `ready` is low while an access is in flight and doubles as the pipeline RAM freeze.
//
// state | meaning
// IDLE  | waiting for rdEn/wrEn; ready follows ~(rdEn | wrEn)
// LOW   | low half-word on the SRAM bus for WAIT_CYCLES cycles
// HIGH  | high half-word on the SRAM bus for WAIT_CYCLES cycles
// DONE  | one-cycle completion; ready = 1, readData valid
module sram_word_controller #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic        rdEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam int            CW       = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [16:0]   idx;
  logic [31:0]   wdata;
  logic          is_wr;
  logic [31:0]   off;
  logic          req;
  logic          last;
  logic          dq_oe;
  logic [15:0]   dq_out;
  logic          unused_bits;

  assign off         = address - BASE_ADDR;
  assign unused_bits = ^{off[31:19], off[1:0]};
  assign req         = rdEn | wrEn;
  assign last        = (cnt == CNT_LAST);

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req)  state_nxt = LOW;
      LOW:     if (last) state_nxt = HIGH;
      HIGH:    if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b1;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = wdata[15:0];
    SRAM_ADDR = {idx, 1'b0};
    case (state)
      IDLE: ready = ~req;
      LOW: begin
        ready     = 1'b0;
        SRAM_WE_N = ~is_wr;
        dq_oe     = is_wr;
      end
      HIGH: begin
        ready     = 1'b0;
        SRAM_WE_N = ~is_wr;
        dq_oe     = is_wr;
        dq_out    = wdata[31:16];
        SRAM_ADDR = {idx, 1'b1};
      end
      default: ;
    endcase
  end

  // Counter restarts on every state change, so LOW and HIGH each start from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (state_nxt != state)  cnt <= '0;
    else if (state == LOW || state == HIGH) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      wdata <= '0;
      is_wr <= 1'b0;
    end else if (state == IDLE && req) begin
      idx   <= off[18:2];
      wdata <= writeData;
      is_wr <= wrEn;
    end
  end

  // Each half is sampled on the final cycle it is held on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readData <= '0;
    end else if (!is_wr && last) begin
      if (state == LOW)  readData[15:0]  <= SRAM_DQ;
      if (state == HIGH) readData[31:16] <= SRAM_DQ;
    end
  end

endmodule
